// File: rtl/item_memory_pkg.sv
// +----------------------------------------------------------------------------+
// | item_memory_pkg : shared types and width helpers for the item memory        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package item_memory_pkg;

  typedef enum logic {
    IM_MODE_CA90 = 1'b0,
    IM_MODE_CIM  = 1'b1
  } im_mode_e;

  // Index width that stays legal for single-entry tables.
  function automatic int unsigned im_index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Level 0 flips nothing, the top level flips half the hypervector.
  function automatic int unsigned cim_flip_count(input int unsigned level,
                                                 input int unsigned hv_dim,
                                                 input int unsigned levels);
    return (level * (hv_dim / 2)) / (levels - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/item_memory_lane.sv
// +----------------------------------------------------------------------------+
// | item_memory_lane : one lookup port - CA90 item expansion or CiM level HV    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module item_memory_lane
  import item_memory_pkg::*;
#(
  parameter int unsigned HVDimension  = 512,
  parameter int unsigned NumPerImBank = 128,
  parameter int unsigned SeedWidth    = 32,
  parameter int unsigned NumImSets    = 8,
  parameter int unsigned NumCimLevels = 256,
  parameter int unsigned ImAddrWidth  = 10
) (
  input  logic                                en_i,
  input  im_mode_e                            mode_i,
  input  logic [ImAddrWidth-1:0]              addr_i,
  input  logic [NumImSets-1:0][SeedWidth-1:0] im_seed_i,
  input  logic [SeedWidth-1:0]                cim_seed_i,
  output logic [HVDimension-1:0]              hv_o
);

  localparam int unsigned BankWidth = im_index_width(NumImSets);
  localparam int unsigned StepWidth = im_index_width(NumPerImBank);
  localparam int unsigned Reps      = HVDimension / SeedWidth;

  // 2^k steps of rule 90 collapse to neighbours at distance 2^k (GF(2) linearity).
  function automatic logic [HVDimension-1:0] ca90_jump(input logic [HVDimension-1:0] x,
                                                        input int unsigned d);
    return ((x << d) | (x >> (HVDimension - d))) ^ ((x >> d) | (x << (HVDimension - d)));
  endfunction

  logic [BankWidth-1:0]   bank;
  logic [StepWidth-1:0]   step;
  logic [ImAddrWidth-1:0] cim_level;
  int unsigned            flips;
  logic [HVDimension-1:0] ca90_hv;
  logic [HVDimension-1:0] cim_mask;
  logic [HVDimension-1:0] cim_hv;

  assign bank = BankWidth'(addr_i / ImAddrWidth'(NumPerImBank));
  assign step = StepWidth'(addr_i % ImAddrWidth'(NumPerImBank));

  always_comb begin
    ca90_hv = {Reps{im_seed_i[bank]}};
    for (int unsigned m = 0; m < StepWidth; m++) begin
      if (step[m]) ca90_hv = ca90_jump(ca90_hv, 1 << m);
    end
  end

  assign cim_level = (addr_i >= ImAddrWidth'(NumCimLevels)) ?
                     ImAddrWidth'(NumCimLevels - 1) : addr_i;
  assign flips     = cim_flip_count(32'(cim_level), HVDimension, NumCimLevels);

  always_comb begin
    cim_mask = '0;
    for (int unsigned i = 0; i < HVDimension; i++) begin
      cim_mask[i] = (i < flips);
    end
  end

  assign cim_hv = {Reps{cim_seed_i}} ^ cim_mask;

  always_comb begin
    hv_o = '0;
    if (en_i) hv_o = (mode_i == IM_MODE_CIM) ? cim_hv : ca90_hv;
  end

endmodule

`default_nettype wire

// File: rtl/item_memory_multiport.sv
// +----------------------------------------------------------------------------+
// | item_memory_multiport : pipelined N-port CA90/CiM item memory with seed cfg |
// | Optional input stage: ITEM_MEMORY_MULTIPORT_IN_REG_EN. Rev 1.0              |
// +----------------------------------------------------------------------------+
`default_nettype none

module item_memory_multiport
  import item_memory_pkg::*;
#(
  parameter  int unsigned HVDimension   = 512,
  parameter  int unsigned NumTotIm      = 1024,
  parameter  int unsigned NumPerImBank  = 128,
  parameter  int unsigned SeedWidth     = 32,
  parameter  int unsigned NumPorts      = 3,
  parameter  int unsigned NumCimLevels  = 256,
  localparam int unsigned ImAddrWidth   = $clog2(NumTotIm),
  localparam int unsigned NumImSets     = NumTotIm / NumPerImBank,
  localparam int unsigned SeedAddrWidth = $clog2(NumImSets + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  cfg_seed_valid_i,
  output logic                                  cfg_seed_ready_o,
  input  logic [SeedAddrWidth-1:0]              cfg_seed_addr_i,
  input  logic [SeedWidth-1:0]                  cfg_seed_data_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [NumPorts-1:0]                   req_port_en_i,
  input  logic [NumPorts-1:0]                   req_cim_i,
  input  logic [NumPorts-1:0][ImAddrWidth-1:0]  req_addr_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [NumPorts-1:0][HVDimension-1:0]  rsp_hv_o
);

  typedef struct packed {
    logic                   en;
    im_mode_e               mode;
    logic [ImAddrWidth-1:0] addr;
  } lane_req_t;

  logic [NumImSets-1:0][SeedWidth-1:0]  im_seed_q, im_seed_d;
  logic [SeedWidth-1:0]                 cim_seed_q, cim_seed_d;
  logic                                 s1_v_q, s1_v_d;
  logic [NumPorts-1:0][HVDimension-1:0] rsp_hv_q, rsp_hv_d;
  lane_req_t [NumPorts-1:0]             in_req;
  lane_req_t [NumPorts-1:0]             lk_req;
  logic [NumPorts-1:0][HVDimension-1:0] lk_hv;
  logic                                 lk_v;
  logic                                 adv;
  logic                                 cfg_fire;
  logic                                 req_fire;

  always_comb begin
    in_req = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      in_req[p].en   = req_port_en_i[p];
      in_req[p].mode = im_mode_e'(req_cim_i[p]);
      in_req[p].addr = req_addr_i[p];
    end
  end

  assign adv = !s1_v_q | rsp_ready_i;

`ifdef ITEM_MEMORY_MULTIPORT_IN_REG_EN
  logic                     s0_v_q, s0_v_d;
  lane_req_t [NumPorts-1:0] s0_req_q, s0_req_d;
  logic                     s0_load;

  // Seed writes only land on an empty pipe and take priority over a new bundle.
  always_comb begin
    s0_load          = !s0_v_q | adv;
    cfg_seed_ready_o = !s0_v_q & !s1_v_q;
    cfg_fire         = cfg_seed_valid_i & cfg_seed_ready_o;
    req_ready_o      = s0_load & !cfg_fire;
    req_fire         = req_valid_i & req_ready_o;
    s0_v_d           = s0_load ? req_fire : s0_v_q;
    s0_req_d         = req_fire ? in_req : s0_req_q;
    lk_v             = s0_v_q;
    lk_req           = s0_req_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_v_q   <= 1'b0;
      s0_req_q <= '0;
    end else begin
      s0_v_q   <= s0_v_d;
      s0_req_q <= s0_req_d;
    end
  end
`else
  always_comb begin
    cfg_seed_ready_o = !s1_v_q;
    cfg_fire         = cfg_seed_valid_i & cfg_seed_ready_o;
    req_ready_o      = adv & !cfg_fire;
    req_fire         = req_valid_i & req_ready_o;
    lk_v             = req_fire;
    lk_req           = in_req;
  end
`endif

  // Addresses beyond the CiM slot are accepted but leave every seed untouched.
  always_comb begin
    im_seed_d  = im_seed_q;
    cim_seed_d = cim_seed_q;
    if (cfg_fire) begin
      for (int unsigned b = 0; b < NumImSets; b++) begin
        if (cfg_seed_addr_i == SeedAddrWidth'(b)) im_seed_d[b] = cfg_seed_data_i;
      end
      if (cfg_seed_addr_i == SeedAddrWidth'(NumImSets)) cim_seed_d = cfg_seed_data_i;
    end
  end

  always_comb begin
    s1_v_d   = adv ? lk_v : s1_v_q;
    rsp_hv_d = (adv & lk_v) ? lk_hv : rsp_hv_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      im_seed_q  <= '0;
      cim_seed_q <= '0;
      s1_v_q     <= 1'b0;
      rsp_hv_q   <= '0;
    end else begin
      im_seed_q  <= im_seed_d;
      cim_seed_q <= cim_seed_d;
      s1_v_q     <= s1_v_d;
      rsp_hv_q   <= rsp_hv_d;
    end
  end

  for (genvar p = 0; p < NumPorts; p++) begin : g_lane
    item_memory_lane #(
      .HVDimension (HVDimension),
      .NumPerImBank(NumPerImBank),
      .SeedWidth   (SeedWidth),
      .NumImSets   (NumImSets),
      .NumCimLevels(NumCimLevels),
      .ImAddrWidth (ImAddrWidth)
    ) u_lane (
      .en_i      (lk_req[p].en),
      .mode_i    (lk_req[p].mode),
      .addr_i    (lk_req[p].addr),
      .im_seed_i (im_seed_q),
      .cim_seed_i(cim_seed_q),
      .hv_o      (lk_hv[p])
    );
  end

  assign rsp_valid_o = s1_v_q;
  assign rsp_hv_o    = rsp_hv_q;

endmodule

`default_nettype wire

// File: tb/tb_item_memory_multiport.sv
// +----------------------------------------------------------------------------+
// | tb_item_memory_multiport : directed self-checking bench for the item memory |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_item_memory_multiport;

  localparam int HV      = 512;
  localparam int NP      = 3;
  localparam int AW      = 10;
  localparam int SW      = 32;
  localparam int NSETS   = 8;
  localparam int PERBANK = 128;
  localparam int NLVL    = 21;
`ifdef ITEM_MEMORY_MULTIPORT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                   clk;
  logic                   rst_ni;
  logic                   cfg_seed_valid_i;
  logic                   cfg_seed_ready_o;
  logic [3:0]             cfg_seed_addr_i;
  logic [SW-1:0]          cfg_seed_data_i;
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [NP-1:0]          req_port_en_i;
  logic [NP-1:0]          req_cim_i;
  logic [NP-1:0][AW-1:0]  req_addr_i;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [NP-1:0][HV-1:0]  rsp_hv_o;

  item_memory_multiport #(
    .HVDimension (HV),
    .NumTotIm    (1024),
    .NumPerImBank(PERBANK),
    .SeedWidth   (SW),
    .NumPorts    (NP),
    .NumCimLevels(NLVL)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .cfg_seed_valid_i(cfg_seed_valid_i),
    .cfg_seed_ready_o(cfg_seed_ready_o),
    .cfg_seed_addr_i (cfg_seed_addr_i),
    .cfg_seed_data_i (cfg_seed_data_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_port_en_i   (req_port_en_i),
    .req_cim_i       (req_cim_i),
    .req_addr_i      (req_addr_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_hv_o        (rsp_hv_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0][HV-1:0] hv;
    int                    cyc;
  } exp_t;

  exp_t          q[$];
  logic [SW-1:0] m_im_seed [NSETS];
  logic [SW-1:0] m_cim_seed;
  int            errors, checks, cyc, rsp_cnt, acc_cnt;
  bit            chk_lat, cfg_fired;
  int            mark;

  function automatic logic [HV-1:0] rep(input logic [SW-1:0] s);
    logic [HV-1:0] r;
    for (int i = 0; i < HV; i++) r[i] = s[i % SW];
    return r;
  endfunction

  // Plain step-by-step rule 90 on a ring.
  function automatic logic [HV-1:0] ca90_model(input logic [SW-1:0] s, input int steps);
    logic [HV-1:0] x, n;
    x = rep(s);
    for (int k = 0; k < steps; k++) begin
      for (int i = 0; i < HV; i++) n[i] = x[(i + HV - 1) % HV] ^ x[(i + 1) % HV];
      x = n;
    end
    return x;
  endfunction

  function automatic logic [HV-1:0] cim_model(input logic [SW-1:0] s, input int addr);
    logic [HV-1:0] x;
    int lvl, nflip;
    lvl   = (addr >= NLVL) ? NLVL - 1 : addr;
    nflip = lvl * (HV / 2) / (NLVL - 1);
    x     = rep(s);
    for (int i = 0; i < nflip; i++) x[i] = ~x[i];
    return x;
  endfunction

  function automatic logic [HV-1:0] exp_port(input logic en, input logic cim, input logic [AW-1:0] addr);
    if (!en) return '0;
    if (cim) return cim_model(m_cim_seed, int'(addr));
    return ca90_model(m_im_seed[int'(addr) / PERBANK], int'(addr) % PERBANK);
  endfunction

  task automatic chk_hv(input string tag, input int p, input logic [HV-1:0] obs, input logic [HV-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s port%0d observed=%h expected=%h", tag, p, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk_int({tag, "_rsp_valid"}, int'(rsp_valid_o), 0);
    for (int p = 0; p < NP; p++) chk_hv({tag, "_rsp_hv"}, p, rsp_hv_o[p], '0);
    chk_int({tag, "_req_ready"}, int'(req_ready_o), 1);
    chk_int({tag, "_cfg_ready"}, int'(cfg_seed_ready_o), 1);
  endtask

  task automatic set_req(input logic v, input logic [NP-1:0] en, input logic [NP-1:0] cim,
                         input int a0, input int a1, input int a2);
    req_valid_i   = v;
    req_port_en_i = en;
    req_cim_i     = cim;
    req_addr_i[0] = AW'(a0);
    req_addr_i[1] = AW'(a1);
    req_addr_i[2] = AW'(a2);
  endtask

  // One clock: check any presented response, track handshakes, advance.
  task automatic cycle();
    exp_t e;
    #1;
    cyc++;
    if (rsp_valid_o) begin
      chk_int("rsp_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        for (int p = 0; p < NP; p++) chk_hv("rsp_hv", p, rsp_hv_o[p], q[0].hv[p]);
        if (rsp_ready_i) begin
          if (chk_lat) chk_int("latency", cyc - q[0].cyc, LAT);
          void'(q.pop_front());
          rsp_cnt++;
        end
      end
    end
    if (cfg_seed_valid_i && cfg_seed_ready_o) begin
      cfg_fired = 1'b1;
      if (int'(cfg_seed_addr_i) < NSETS) m_im_seed[int'(cfg_seed_addr_i)] = cfg_seed_data_i;
      else if (int'(cfg_seed_addr_i) == NSETS) m_cim_seed = cfg_seed_data_i;
    end
    if (req_valid_i && req_ready_o) begin
      for (int p = 0; p < NP; p++) e.hv[p] = exp_port(req_port_en_i[p], req_cim_i[p], req_addr_i[p]);
      e.cyc = cyc;
      q.push_back(e);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && q.size() != 0; n++) cycle();
    chk_int("drain_empty", q.size(), 0);
  endtask

  task automatic cfg_write(input int addr, input logic [SW-1:0] data);
    cfg_seed_valid_i = 1'b1;
    cfg_seed_addr_i  = 4'(addr);
    cfg_seed_data_i  = data;
    cfg_fired        = 1'b0;
    for (int n = 0; n < 40 && !cfg_fired; n++) cycle();
    cfg_seed_valid_i = 1'b0;
    chk_int("cfg_accept", int'(cfg_fired), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; cyc = 0; rsp_cnt = 0; acc_cnt = 0;
    chk_lat = 1'b0; cfg_fired = 1'b0;
    for (int b = 0; b < NSETS; b++) m_im_seed[b] = '0;
    m_cim_seed       = '0;
    rst_ni           = 1'b0;
    cfg_seed_valid_i = 1'b0;
    cfg_seed_addr_i  = '0;
    cfg_seed_data_i  = '0;
    rsp_ready_i      = 1'b1;
    set_req(1'b0, '0, '0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // CiM seed, then bank0 seed racing a request: config must win.
    cfg_write(NSETS, 32'hCAFE_F00D);
    cfg_seed_valid_i = 1'b1;
    cfg_seed_addr_i  = 4'd0;
    cfg_seed_data_i  = 32'h1234_5678;
    set_req(1'b1, 3'b011, 3'b010, 5, 0, 0);
    #1;
    chk_int("cfg_priority_req_ready", int'(req_ready_o), 0);
    chk_int("cfg_priority_cfg_ready", int'(cfg_seed_ready_o), 1);
    cycle();
    cfg_seed_valid_i = 1'b0;
    chk_lat = 1'b1;
    mark = rsp_cnt;
    cycle();
    req_valid_i = 1'b0;
    for (int n = 0; n < 10 && !rsp_valid_o; n++) cycle();
    chk_hv("first_cim_lvl0", 1, rsp_hv_o[1], {16{32'hCAFE_F00D}});
    chk_hv("first_disabled", 2, rsp_hv_o[2], '0);
    drain();
    chk_int("first_rsp_count", rsp_cnt - mark, 1);

    // 16 back-to-back bundles with the consumer always ready.
    mark = rsp_cnt;
    for (int i = 0; i < 16; i++) begin
      set_req(1'b1, {i[0], 2'b11}, 3'b110, i, i, 10 * i);
      cycle();
    end
    req_valid_i = 1'b0;
    drain();
    chk_int("b2b_rsp_count", rsp_cnt - mark, 16);
    chk_lat = 1'b0;

    // Consumer stalls from an empty pipe: exactly LAT bundles fit.
    rsp_ready_i = 1'b0;
    mark = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 3'b111, 3'b010, 16 + i, 200 + i, 1000 + i);
      cycle();
    end
    chk_int("stall_queued", acc_cnt - mark, LAT);
    chk_int("stall_req_ready_low", int'(req_ready_o), 0);
    rsp_ready_i = 1'b1;
    mark = rsp_cnt;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 3'b111, 3'b000, 300 + i, 400 + i, 500 + i);
      cycle();
    end
    req_valid_i = 1'b0;
    drain();
    chk_int("stall_no_loss", rsp_cnt - mark, LAT + 3);

    // Bank1 seed write while an address-130 lookup is in flight.
    set_req(1'b1, 3'b001, 3'b000, 130, 0, 0);
    cycle();
    req_valid_i      = 1'b0;
    rsp_ready_i      = 1'b0;
    cfg_seed_valid_i = 1'b1;
    cfg_seed_addr_i  = 4'd1;
    cfg_seed_data_i  = 32'hA5A5_0F0F;
    cfg_fired        = 1'b0;
    #1;
    chk_int("cfg_blocked_inflight", int'(cfg_seed_ready_o), 0);
    cycle();
    cycle();
    chk_int("cfg_blocked_stalled", int'(cfg_seed_ready_o), 0);
    rsp_ready_i = 1'b1;
    for (int n = 0; n < 20 && !cfg_fired; n++) cycle();
    cfg_seed_valid_i = 1'b0;
    chk_int("cfg_after_drain", int'(cfg_fired), 1);
    chk_int("cfg_pipe_drained", q.size(), 0);
    set_req(1'b1, 3'b111, 3'b000, 130, 129, 255);
    cycle();
    req_valid_i = 1'b0;
    drain();

    // CiM saturation, then a write beyond the CiM slot must change nothing.
    set_req(1'b1, 3'b111, 3'b110, 130, 300, 20);
    cycle();
    req_valid_i = 1'b0;
    drain();
    cfg_write(NSETS + 1, 32'hFFFF_FFFF);
    set_req(1'b1, 3'b111, 3'b110, 5, 300, 3);
    cycle();
    req_valid_i = 1'b0;
    drain();

    // Asynchronous reset with bundles in flight.
    rsp_ready_i = 1'b0;
    set_req(1'b1, 3'b111, 3'b010, 5, 10, 7);
    cycle();
    set_req(1'b1, 3'b111, 3'b010, 6, 11, 8);
    cycle();
    req_valid_i = 1'b0;
    rst_ni      = 1'b0;
    #1;
    chk_idle("midreset");
    q.delete();
    for (int b = 0; b < NSETS; b++) m_im_seed[b] = '0;
    m_cim_seed = '0;
    @(posedge clk);
    #1;
    rst_ni      = 1'b1;
    rsp_ready_i = 1'b1;
    for (int n = 0; n < 3; n++) cycle();
    chk_int("no_rsp_after_reset", int'(rsp_valid_o), 0);
    set_req(1'b1, 3'b111, 3'b010, 5, 20, 135);
    cycle();
    req_valid_i = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
